// File: rtl/gba_event_bridge_if.sv
// gba_event_bridge_if
//   Groups the event-side inputs and the mclk-slot outputs of gba_event_bridge.
//   master: the event source / consumer side (drives mclk, evt_in, clr).
//   slave : the bridge itself (drives pulse_out, pending, overflow, slot_end).
//   Signals:
//     mclk       mclk level, sampled as data for slot alignment
//     evt_in     N single-cycle fclk event strobes
//     clr        synchronous flush of pending counts, overflow flags and pulses
//     pulse_out  N mclk-slot pulses
//     pending    N channel has undelivered events
//     overflow   N sticky lost-event flags (count-mode channels)
//     slot_end   1-cycle strobe when pulse_out updates
`timescale 1ns/1ps
interface gba_event_bridge_if #(
    parameter int unsigned N = 4
) ();
    logic         mclk;
    logic [N-1:0] evt_in;
    logic         clr;
    logic [N-1:0] pulse_out;
    logic [N-1:0] pending;
    logic [N-1:0] overflow;
    logic         slot_end;

    modport master (
        output mclk, evt_in, clr,
        input  pulse_out, pending, overflow, slot_end
    );

    modport slave (
        input  mclk, evt_in, clr,
        output pulse_out, pending, overflow, slot_end
    );
endinterface

// File: rtl/gba_event_bridge.sv
// gba_event_bridge
//   N-channel bridge from fclk-domain single-cycle event strobes to pulses that
//   last exactly one mclk period (RATIO fclk cycles) and are aligned to mclk.
//   Each channel either merges events (any number per slot -> one pulse) or
//   counts them (one pulse slot per event, saturating counter, sticky overflow).
//   Ports:
//     fclk      fast clock, all state on its rising edge
//     reset_n   asynchronous active-low reset
//     bus       gba_event_bridge_if slave modport (mclk, evt_in, clr in;
//               pulse_out, pending, overflow, slot_end out)
`timescale 1ns/1ps
module gba_event_bridge #(
    parameter int unsigned   N          = 4,
    parameter int unsigned   RATIO      = 4,
    parameter int unsigned   CNT_W      = 3,
    parameter logic [N-1:0]  COUNT_MASK = '0
) (
    input  logic                   fclk,
    input  logic                   reset_n,
    gba_event_bridge_if.slave      bus
);
    localparam int unsigned       SW   = ($clog2(RATIO) > 1) ? $clog2(RATIO) : 1;
    localparam logic [SW-1:0]     LAST = SW'(RATIO - 1);
    localparam logic [CNT_W-1:0]  CMAX = '1;

    logic [SW-1:0]    slot_q, slot_d;
    logic             mclk_q;
    logic             slot_end_q;
    logic [N-1:0]     pulse_q, pulse_d;
    logic [N-1:0]     ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q [N];
    logic [CNT_W-1:0] cnt_d [N];

    logic boundary;
    logic mclk_rise;

    assign boundary  = (slot_q == LAST);
    assign mclk_rise = bus.mclk & ~mclk_q;

    // A rising mclk edge re-phases the counter so the next boundary lands on
    // the last fclk cycle before the following mclk rise; a boundary on the
    // same cycle still launches its pulses.
    always_comb begin
        slot_d = slot_q + SW'(1);
        if (mclk_rise) begin
            slot_d = SW'(1);
        end else if (boundary) begin
            slot_d = '0;
        end
    end

    always_comb begin
        logic dec;
        dec     = 1'b0;
        pulse_d = pulse_q;
        ovf_d   = ovf_q;
        for (int unsigned i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            dec      = 1'b0;
            if (bus.clr) begin
                cnt_d[i]   = '0;
                pulse_d[i] = 1'b0;
                ovf_d[i]   = 1'b0;
            end else if (COUNT_MASK[i]) begin
                dec = boundary && (cnt_q[i] != '0);
                if (boundary) begin
                    pulse_d[i] = (cnt_q[i] != '0);
                end
                if (bus.evt_in[i] && (cnt_q[i] == CMAX) && !dec) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(dec) + CNT_W'(bus.evt_in[i]);
                end
            end else begin
                // Merge mode: the counter is a 1-bit flag. A boundary-cycle
                // event restarts the flag so it belongs to the next slot.
                if (boundary) begin
                    pulse_d[i] = (cnt_q[i] != '0);
                    cnt_d[i]   = CNT_W'(bus.evt_in[i]);
                end else begin
                    cnt_d[i]   = CNT_W'((cnt_q[i] != '0) | bus.evt_in[i]);
                end
            end
        end
    end

    always_ff @(posedge fclk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q     <= '0;
            mclk_q     <= 1'b0;
            slot_end_q <= 1'b0;
            pulse_q    <= '0;
            ovf_q      <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            slot_q     <= slot_d;
            mclk_q     <= bus.mclk;
            slot_end_q <= boundary;
            pulse_q    <= pulse_d;
            ovf_q      <= ovf_d;
            for (int unsigned i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        bus.pending = '0;
        for (int unsigned i = 0; i < N; i++) begin
            bus.pending[i] = (cnt_q[i] != '0);
        end
    end

    assign bus.pulse_out = pulse_q;
    assign bus.overflow  = ovf_q;
    assign bus.slot_end  = slot_end_q;
endmodule
